// File: rtl/acc_readout_serializer.sv
// Purpose : snapshot the matmul core's NxN accumulator tile, requantize each element to int8, stream row-major.
// Latency : capture on edge k, first out_valid in cycle k+1; one tile per N*N+1 cycles with out_ready held high.
// Backpress: out_ready low stalls the stream; out_data/out_last/idx hold, no new tile is accepted until the last transfer.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   acc_in, acc_valid   flattened tile (element i at [i*ACC_W +: ACC_W]) and its valid; acc_valid held until acc_taken
//   acc_taken           combinational, high in the cycle the tile is captured (IDLE && acc_valid)
//   shift               requantization right shift 0..7, sampled at capture
//   out_data/out_valid/out_ready/out_last   int8 output stream with last-element marker
//   busy                high while streaming a tile
//   sat_flag            sticky, set when any transferred element of the current tile clamped
module acc_readout_serializer #(
    parameter int N     = 4,
    parameter int ACC_W = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N*N*ACC_W-1:0]   acc_in,
    input  logic                   acc_valid,
    output logic                   acc_taken,
    input  logic [2:0]             shift,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   sat_flag
);

    localparam int ELEMS = N * N;
    localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);
    localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] Q_MIN = (ACC_W+1)'(-128);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                   state_q, state_nxt;
    logic signed [ACC_W-1:0]  shadow_q [ELEMS];
    logic [2:0]               shift_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     capture;
    logic                     xfer;

    logic signed [ACC_W:0]    cur_ext;
    logic signed [ACC_W:0]    rnd;
    logic signed [ACC_W:0]    sum;
    logic signed [ACC_W:0]    shifted;
    logic [7:0]               q_dat;
    logic                     q_sat;

    // Requantize the element currently addressed by idx_q. One extra bit of
    // headroom keeps the rounding add from overflowing for any ACC_W input.
    always_comb begin
        cur_ext = {shadow_q[idx_q][ACC_W-1], shadow_q[idx_q]};
        rnd     = '0;
        if (shift_q != 3'd0) begin
            rnd[shift_q - 3'd1] = 1'b1;
        end
        sum     = cur_ext + rnd;
        shifted = sum >>> shift_q;
        q_sat   = 1'b0;
        q_dat   = shifted[7:0];
        if (shifted > Q_MAX) begin
            q_dat = 8'h7F;
            q_sat = 1'b1;
        end else if (shifted < Q_MIN) begin
            q_dat = 8'h80;
            q_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state and outputs. Stream outputs depend only on registered state,
    // so a stalled cycle presents exactly the same element again.
    always_comb begin
        state_nxt = state_q;
        acc_taken = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        busy      = 1'b0;
        capture   = 1'b0;
        xfer      = 1'b0;
        case (state_q)
            IDLE: begin
                acc_taken = acc_valid;
                if (acc_valid) begin
                    capture   = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = q_dat;
                out_last  = (idx_q == LAST_IDX);
                xfer      = out_ready;
                if (out_ready && (idx_q == LAST_IDX)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ELEMS; i++) begin
                shadow_q[i] <= '0;
            end
            shift_q  <= 3'd0;
            idx_q    <= '0;
            sat_flag <= 1'b0;
        end else if (capture) begin
            for (int i = 0; i < ELEMS; i++) begin
                shadow_q[i] <= acc_in[i*ACC_W +: ACC_W];
            end
            shift_q  <= shift;
            idx_q    <= '0;
            sat_flag <= 1'b0;
        end else if (xfer) begin
            sat_flag <= sat_flag | q_sat;
            idx_q    <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_acc_readout_serializer.sv
// Purpose : self-checking bench for acc_readout_serializer against an arithmetic requantization model.
// Latency : inputs driven 1 time unit after each rising edge, outputs sampled 1 unit later.
// Backpress: out_ready driven always-high, alternating, or random per scenario.
module tb_acc_readout_serializer;

    localparam int N     = 4;
    localparam int ACC_W = 17;
    localparam int E     = N * N;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N*N*ACC_W-1:0]  acc_in;
    logic                  acc_valid;
    logic                  acc_taken;
    logic [2:0]            shift;
    logic [7:0]            out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;
    logic                  sat_flag;

    acc_readout_serializer #(.N(N), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .acc_in    (acc_in),
        .acc_valid (acc_valid),
        .acc_taken (acc_taken),
        .shift     (shift),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int tile  [E];
    int exp_d [E];
    bit exp_s [E];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Round-half-up divide by 2^s, then clamp to int8.
    function automatic void requant(input int x, input int s, output int y, output bit sat);
        int v;
        if (s == 0) v = x;
        else        v = (x + (1 << (s - 1))) >>> s;
        sat = 1'b0;
        y   = v;
        if (v > 127) begin
            y   = 127;
            sat = 1'b1;
        end else if (v < -128) begin
            y   = -128;
            sat = 1'b1;
        end
    endfunction

    function automatic int rand_elem();
        case ($urandom_range(0, 2))
            0:       return int'($urandom_range(0, 400)) - 200;
            1:       return int'($urandom_range(0, 131071)) - 65536;
            default: return int'($urandom_range(0, 40000)) - 20000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_tile();
        for (int i = 0; i < E; i++) begin
            acc_in[i*ACC_W +: ACC_W] = ACC_W'(tile[i]);
        end
    endtask

    // Called in an IDLE cycle; presents the tile, checks acc_taken, clocks the capture.
    task automatic start_capture(input int s, input bit hold, input string tag);
        drive_tile();
        shift     = 3'(s);
        acc_valid = 1'b1;
        for (int i = 0; i < E; i++) begin
            requant(tile[i], s, exp_d[i], exp_s[i]);
        end
        #1;
        check({tag, ":taken"}, int'(acc_taken), 1);
        check({tag, ":idle_valid"}, int'(out_valid), 0);
        tick();
        if (!hold) acc_valid = 1'b0;
    endtask

    // mode 0: ready high, 1: alternate 1,0,..., 2: random.
    task automatic stream(input int mode, input bit hold, input bit scramble, input int limit, input string tag);
        int n      = 0;
        int cyc    = 0;
        int prev_d = 0;
        int prev_l = 0;
        bit stalled = 1'b0;
        bit sat_acc = 1'b0;
        bit rdy;
        while (n < limit && cyc < 400) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (scramble) begin
                for (int i = 0; i < E; i++) begin
                    acc_in[i*ACC_W +: ACC_W] = ACC_W'($urandom);
                end
                shift = 3'($urandom);
            end
            #1;
            check({tag, ":valid"}, int'(out_valid), 1);
            check({tag, ":busy"}, int'(busy), 1);
            check({tag, ":taken_in_stream"}, int'(acc_taken), 0);
            check({tag, ":sat_flag"}, int'(sat_flag), int'(sat_acc));
            if (stalled) begin
                check({tag, ":stall_data"}, int'($signed(out_data)), prev_d);
                check({tag, ":stall_last"}, int'(out_last), prev_l);
            end
            if (rdy) begin
                check({tag, ":data"}, int'($signed(out_data)), exp_d[n]);
                check({tag, ":last"}, int'(out_last), int'(n == E - 1));
                sat_acc = sat_acc | exp_s[n];
                n++;
            end
            stalled = !rdy;
            prev_d  = int'($signed(out_data));
            prev_l  = int'(out_last);
            cyc++;
            tick();
        end
        if (n < limit) check({tag, ":timeout_transfers"}, n, limit);
        if (limit == E) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check({tag, ":end_valid"}, int'(out_valid), 0);
            check({tag, ":end_busy"}, int'(busy), 0);
            check({tag, ":end_last"}, int'(out_last), 0);
            check({tag, ":end_data"}, int'(out_data), 0);
            check({tag, ":end_sat"}, int'(sat_flag), int'(sat_acc));
            check({tag, ":end_taken"}, int'(acc_taken), int'(hold));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ":valid"}, int'(out_valid), 0);
        check({tag, ":busy"}, int'(busy), 0);
        check({tag, ":data"}, int'(out_data), 0);
        check({tag, ":last"}, int'(out_last), 0);
        check({tag, ":sat"}, int'(sat_flag), 0);
        check({tag, ":taken"}, int'(acc_taken), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        reset     = 1'b1;
        acc_valid = 1'b0;
        out_ready = 1'b0;
        shift     = 3'd0;
        acc_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;
        tick();
        check_idle("post_reset");

        // Basic ramp, shift 0.
        for (int i = 0; i < E; i++) tile[i] = i;
        start_capture(0, 1'b0, "basic");
        stream(0, 1'b0, 1'b0, E, "basic");

        // Rounding, shift 2.
        tile[0] = 6; tile[1] = -6; tile[2] = 5; tile[3] = -2;
        for (int i = 4; i < E; i++) tile[i] = int'($urandom_range(0, 400)) - 200;
        start_capture(2, 1'b0, "round");
        stream(0, 1'b0, 1'b0, E, "round");

        // Large positive with shift 7 clamps.
        tile[0] = 65535;
        for (int i = 1; i < E; i++) tile[i] = rand_elem();
        start_capture(7, 1'b0, "shift7");
        stream(0, 1'b0, 1'b0, E, "shift7");

        // Saturation with shift 0.
        tile[0] = 300; tile[1] = -300; tile[2] = 127; tile[3] = -128;
        for (int i = 4; i < E; i++) tile[i] = int'($urandom_range(0, 200)) - 100;
        start_capture(0, 1'b0, "sat");
        stream(0, 1'b0, 1'b0, E, "sat");

        // In-range tile clears the sticky flag.
        for (int i = 0; i < E; i++) tile[i] = int'($urandom_range(0, 255)) - 128;
        start_capture(0, 1'b0, "clear");
        stream(0, 1'b0, 1'b0, E, "clear");

        // Alternating backpressure with inputs scrambled mid-stream.
        for (int i = 0; i < E; i++) tile[i] = rand_elem();
        start_capture(int'($urandom_range(0, 7)), 1'b0, "bp");
        stream(1, 1'b0, 1'b1, E, "bp");

        // Random tiles, shifts and ready patterns.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < E; i++) tile[i] = rand_elem();
            start_capture(int'($urandom_range(0, 7)), 1'b0, "rand");
            stream(2, 1'b0, 1'($urandom_range(0, 1)), E, "rand");
        end

        // acc_valid held across two tiles: second capture right after tile 1 ends.
        for (int i = 0; i < E; i++) tile[i] = rand_elem();
        start_capture(int'($urandom_range(0, 7)), 1'b1, "coll1");
        for (int i = 0; i < E; i++) tile[i] = rand_elem();
        s = int'($urandom_range(0, 7));
        drive_tile();
        shift = 3'(s);
        stream(0, 1'b1, 1'b0, E, "coll1");
        start_capture(s, 1'b0, "coll2");
        stream(0, 1'b0, 1'b0, E, "coll2");

        // Asynchronous reset after 5 transfers of a tile that has already saturated.
        tile[0] = 1000;
        for (int i = 1; i < E; i++) tile[i] = rand_elem();
        start_capture(0, 1'b0, "rst_pre");
        stream(0, 1'b0, 1'b0, 5, "rst_pre");
        check("rst_pre:sat_before", int'(sat_flag), 1);
        #3;
        reset = 1'b1;
        #1;
        check("rst_async:valid", int'(out_valid), 0);
        check("rst_async:busy", int'(busy), 0);
        check("rst_async:data", int'(out_data), 0);
        check("rst_async:sat", int'(sat_flag), 0);
        check("rst_async:last", int'(out_last), 0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rst_after:valid", int'(out_valid), 0);
            check("rst_after:busy", int'(busy), 0);
        end
        for (int i = 0; i < E; i++) tile[i] = rand_elem();
        start_capture(int'($urandom_range(0, 7)), 1'b0, "rst_new");
        stream(2, 1'b0, 1'b0, E, "rst_new");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_readout_serializer.md
Name: acc_readout_serializer

Overview:
- Output stage directly downstream of the e2m0 x int8 matmul core.
- Snapshots the core's N×N accumulator tile in one cycle, so the core can clear and start the next tile.
- Requantizes each accumulator to int8 using a programmable arithmetic right shift, round-half-up and saturation.
- Streams the results one byte per handshake toward uo_out, in row-major order.

Parameters:
- N, 4: array dimension; the tile holds N*N accumulators.
- ACC_W, 17: signed accumulator width, two's complement.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- acc_in  in  N*N*ACC_W  flattened tile; element i (row-major) at bits [i*ACC_W +: ACC_W].
- acc_valid  in  1  core asserts while the tile is final; held until acc_taken.
- acc_taken  out  1  combinational; high in the cycle the tile is captured.
- shift  in  3  requantization shift 0..7; sampled at capture.
- out_data  out  8  signed int8 result.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- out_last  out  1  high with the final element of a tile.
- busy  out  1  high while in STREAM.
- sat_flag  out  1  sticky; set if any element of the current tile saturated.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, idx=0, shadow registers=0, shift_q=0, sat_flag=0.
  - All outputs 0.
- FSM states: IDLE, STREAM.
- IDLE:
  - out_valid=0, out_data=0, out_last=0, busy=0.
  - acc_taken = acc_valid (combinational).
  - If acc_valid: capture all N*N elements into shadow regs, shift_q<=shift, idx<=0, sat_flag<=0, state<=STREAM.
- STREAM:
  - busy=1, out_valid=1, acc_taken=0; acc_valid is ignored.
  - out_data = q(shadow[idx]). out_data and out_last are functions of registered state only.
  - out_last = (idx == N*N-1).
  - Transfer when out_valid && out_ready:
    - idx<=idx+1.
    - sat_flag<=sat_flag | sat(shadow[idx]).
    - If out_last: state<=IDLE, idx<=0.
  - Stall (out_ready=0): out_data, out_last and idx hold stable.
- Latency:
  - Capture at edge k; first out_valid=1 in cycle k+1.
  - With out_ready tied high, one tile takes N*N cycles of output plus one IDLE cycle. Back-to-back tile throughput is therefore one tile per N*N+1 cycles.
- Simultaneous events:
  - A last transfer with acc_valid high in the same cycle does not capture. Capture happens in the following IDLE cycle, where acc_taken=1.
  - acc_valid high throughout STREAM is ignored, and acc_taken stays low.
- Requantization q(x), computed in ACC_W+1 bits:
  - shift_q=0: y = x.
  - Otherwise: y = (x + (1 << (shift_q-1))) >>> shift_q, an arithmetic shift.
  - Saturate y to [-128, 127]. sat(x) is 1 when clamping occurred.
- sat_flag:
  - Accumulates over the elements transferred in the current tile.
  - Remains readable in IDLE after the tile finishes.
  - Clears at the next capture.
- Reset asserted mid-stream:
  - Outputs drop to 0 at once and the partial tile is discarded.
  - After release, the block is in IDLE, awaiting a new acc_valid.

Test Plan:
- Basic stream: N=4, ACC_W=17, shift=0, acc_in[i]=i, acc_valid pulse, out_ready=1.
  - acc_taken high for exactly 1 cycle.
  - out_data 0..15 on consecutive cycles; out_last only with 15.
  - busy low after the 16th transfer; sat_flag=0.
- Rounding: shift=2 with elements 6, -6, 5, -2.
  - Outputs 2, -1, 1, 0.
  - shift=7 with 65535 gives 127 and sets sat_flag.
- Saturation: shift=0 with elements 300, -300, 127, -128.
  - Outputs 127, -128, 127, -128; sat_flag=1 after the transfer of 300.
  - Next capture with in-range data clears sat_flag to 0.
- Backpressure: out_ready toggled 1,0,1,0...
  - out_data and out_last stable on every stalled cycle.
  - Exactly 16 transfers, in order.
  - Changing acc_in and shift during the stream does not affect the emitted values.
- Capture collision: acc_valid held high continuously across two tiles.
  - acc_taken=0 throughout STREAM.
  - Second capture occurs exactly one cycle after the last transfer of tile 1.
  - Tile 2 first out_valid follows one cycle later.
- Async reset: assert reset between clock edges after 5 transfers.
  - out_valid, busy, out_data and sat_flag go to 0 before the next edge.
  - After release, no output until a new acc_valid; the new tile starts at element 0.
